stress_vote_counter: RTL and testbench

STRESS_VOTE_COUNTER -- requirements
Module: stress_vote_counter

---
 rtl/stress_vote_counter.sv | 100 ++++++++++
 tb/tb_stress_vote_counter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/stress_vote_counter.sv
// Windowed majority vote over classifier samples: counts votes per class for WINDOW
// accepted samples, then holds the winning class until the consumer takes it.
// Optional macro STRESS_THRESH_EN adds the thresh input and the stress_flag output.
module stress_vote_counter #(
    parameter int NUM_CLASSES  = 2,
    parameter int CNT_W        = 11,
    parameter int WINDOW       = 1024,
`ifdef STRESS_THRESH_EN
    parameter int STRESS_CLASS = 1,
`endif
    localparam int CLS_W       = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                         clk,
    input  logic                         RESET,
    input  logic                         init,
    input  logic                         in_valid,
    input  logic [CLS_W-1:0]             in_class,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CLS_W-1:0]             out_class,
    output logic [CNT_W-1:0]             out_count,
    output logic [NUM_CLASSES*CNT_W-1:0] counts,
`ifdef STRESS_THRESH_EN
    input  logic [CNT_W-1:0]             thresh,
    output logic                         stress_flag,
`endif
    output logic                         bad_class
);

    localparam int SMP_W = (WINDOW > 1) ? $clog2(WINDOW + 1) : 1;

    typedef enum logic {ACCUM, REPORT} state_t;

    state_t             r_state;
    logic [SMP_W-1:0]   r_smp;
    logic               r_bad;
    logic [CNT_W-1:0]   r_cnt [NUM_CLASSES];

    logic [CLS_W-1:0]   w_best_cls;
    logic [CNT_W-1:0]   w_best_cnt;
    logic               w_in_range;

    assign w_in_range = 32'(in_class) < NUM_CLASSES;

    always_ff @(posedge clk) begin
        if (RESET || init) begin
            r_state <= ACCUM;
            r_smp   <= '0;
            r_bad   <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) r_cnt[k] <= '0;
        end else if (r_state == REPORT) begin
            if (out_ready) begin
                r_state <= ACCUM;
                r_smp   <= '0;
                for (int k = 0; k < NUM_CLASSES; k++) r_cnt[k] <= '0;
            end
        end else if (in_valid) begin
            // Out-of-range samples still consume a window slot.
            if (r_smp == SMP_W'(WINDOW - 1)) begin
                r_state <= REPORT;
                r_smp   <= '0;
            end else begin
                r_smp   <= r_smp + 1'b1;
            end
            if (!w_in_range) r_bad <= 1'b1;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                if (in_class == CLS_W'(k) && r_cnt[k] != {CNT_W{1'b1}})
                    r_cnt[k] <= r_cnt[k] + 1'b1;
            end
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        w_best_cls = '0;
        w_best_cnt = r_cnt[0];
        for (int k = 1; k < NUM_CLASSES; k++) begin
            if (r_cnt[k] > w_best_cnt) begin
                w_best_cnt = r_cnt[k];
                w_best_cls = CLS_W'(k);
            end
        end
    end

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_counts
        assign counts[g*CNT_W +: CNT_W] = r_cnt[g];
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == REPORT);
    assign out_class = out_valid ? w_best_cls : '0;
    assign out_count = out_valid ? w_best_cnt : '0;
    assign bad_class = r_bad;

`ifdef STRESS_THRESH_EN
    assign stress_flag = out_valid && (r_cnt[STRESS_CLASS] >= thresh);
`endif

endmodule

// File: tb/tb_stress_vote_counter.sv
// Checks stress_vote_counter against a per-cycle vote-tally model (3 classes,
// 2-bit counters, window of 5) using directed scenarios followed by random traffic.
module tb_stress_vote_counter;

    localparam int NC    = 3;
    localparam int CW    = 2;
    localparam int WIN   = 5;
    localparam int CLS_W = 2;
    localparam int MAXC  = 3;

    logic              clk = 1'b0;
    logic              RESET = 1'b1;
    logic              init = 1'b0;
    logic              in_valid = 1'b0;
    logic [CLS_W-1:0]  in_class = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CLS_W-1:0]  out_class;
    logic [CW-1:0]     out_count;
    logic [NC*CW-1:0]  counts;
    logic              bad_class;
`ifdef STRESS_THRESH_EN
    logic [CW-1:0]     thresh = '0;
    logic              stress_flag;
`endif

    stress_vote_counter #(.NUM_CLASSES(NC), .CNT_W(CW), .WINDOW(WIN)) dut (
        .clk(clk), .RESET(RESET), .init(init),
        .in_valid(in_valid), .in_class(in_class), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_count(out_count),
        .counts(counts),
`ifdef STRESS_THRESH_EN
        .thresh(thresh), .stress_flag(stress_flag),
`endif
        .bad_class(bad_class)
    );

    always #5 clk = ~clk;

    // Reference state: raw vote tallies, accepted count, report phase, sticky error.
    int votes [NC];
    int nacc;
    bit rep;
    bit bad;
    int cur_th;
    int nasrt = 0;
    int nfail = 0;

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int ecls, ecnt;
        logic [NC*CW-1:0] ecounts;
        ecls = 0;
        ecnt = sat(votes[0]);
        for (int k = 1; k < NC; k++)
            if (sat(votes[k]) > ecnt) begin ecnt = sat(votes[k]); ecls = k; end
        if (!rep) begin ecls = 0; ecnt = 0; end
        for (int k = 0; k < NC; k++) ecounts[k*CW +: CW] = CW'(sat(votes[k]));
        chk("in_ready",  32'(in_ready),  32'(!rep));
        chk("out_valid", 32'(out_valid), 32'(rep));
        chk("out_class", 32'(out_class), 32'(ecls));
        chk("out_count", 32'(out_count), 32'(ecnt));
        chk("counts",    32'(counts),    32'(ecounts));
        chk("bad_class", 32'(bad_class), 32'(bad));
`ifdef STRESS_THRESH_EN
        chk("stress_flag", 32'(stress_flag), 32'(rep && sat(votes[1]) >= cur_th));
`endif
    endtask

    task automatic clear_window();
        for (int k = 0; k < NC; k++) votes[k] = 0;
        nacc = 0;
    endtask

    task automatic cyc(input bit v, input int c, input bit ordy, input bit ini,
                       input bit rst, input int th);
        in_valid  = v;
        in_class  = CLS_W'(c);
        out_ready = ordy;
        init      = ini;
        RESET     = rst;
        cur_th    = th;
`ifdef STRESS_THRESH_EN
        thresh    = CW'(th);
`endif
        @(posedge clk);
        if (rst || ini) begin
            clear_window(); rep = 0; bad = 0;
        end else if (rep) begin
            if (ordy) begin clear_window(); rep = 0; end
        end else if (v) begin
            nacc++;
            if (c < NC) votes[c]++; else bad = 1;
            if (nacc == WIN) rep = 1;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input int c);
        cyc(1, c, 0, 0, 0, 3);
    endtask

    initial begin
        clear_window(); rep = 0; bad = 0; cur_th = 0;
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_counts", 32'(counts), 32'd0);

        // Majority window with a stalled consumer and valid still asserted.
        send(1); send(1); send(0); send(1); send(2);
        chk("maj_class", 32'(out_class), 32'd1);
        chk("maj_count", 32'(out_count), 32'd3);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 3);
        chk("hold_class", 32'(out_class), 32'd1);
        chk("hold_count", 32'(out_count), 32'd3);
        cyc(0, 0, 1, 0, 0, 3);
        chk("hs_valid", 32'(out_valid), 32'd0);

        // Out-of-range class, then saturation of class 0.
        send(3);
        chk("bad_set", 32'(bad_class), 32'd1);
        chk("bad_counts", 32'(counts), 32'd0);
        send(0); send(0); send(0); send(0);
        chk("sat_class", 32'(out_class), 32'd0);
        chk("sat_count", 32'(out_count), 32'd3);
        cyc(0, 0, 1, 0, 0, 3);
        chk("bad_kept", 32'(bad_class), 32'd1);
        cyc(0, 0, 0, 1, 0, 3);
        chk("bad_init", 32'(bad_class), 32'd0);

        // init mid-window restarts the tally; RESET in REPORT drops the decision.
        send(0); send(0);
        cyc(1, 0, 0, 1, 0, 3);
        send(2); send(2); send(2); send(0); send(1);
        chk("init_class", 32'(out_class), 32'd2);
        chk("init_count", 32'(out_count), 32'd3);
        cyc(0, 0, 0, 0, 1, 3);
        chk("rst_rep_valid", 32'(out_valid), 32'd0);
        cyc(0, 0, 0, 0, 0, 3);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0,
                $urandom_range(0, 79) == 0, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule
